// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, controller state type and digit check
//
// Purpose: common definitions for the serial BCD adder controller and its
//          digit-pair adder slice.
// Contents:
//   BCD_DIGIT_W     bits per packed BCD digit
//   BCD_MAX         largest legal digit value
//   BCD_RADIX       decimal radix, subtracted on a digit overflow
//   bcdStateT       controller states IDLE / ADD / DONE
//   bcd_digit_valid 1 when a 4-bit digit holds 0..9
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    localparam int BCD_RADIX   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } bcdStateT;

    function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] digit);
        return digit <= BCD_DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_pair_adder.sv
// rtl/bcd_pair_adder.sv - combinational two-digit BCD adder slice
//
// Purpose: adds one pair of BCD digits from each operand plus a decimal
//          carry; the low digit's carry ripples into the high digit.
// Ports:
//   aLo, aHi   in   operand A digits (low, high)
//   bLo, bHi   in   operand B digits (low, high)
//   cin        in   decimal carry into the low digit
//   sumLo      out  low result digit
//   sumHi      out  high result digit
//   cout       out  decimal carry out of the high digit
module bcd_pair_adder
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] aLo,
    input  logic [BCD_DIGIT_W-1:0] aHi,
    input  logic [BCD_DIGIT_W-1:0] bLo,
    input  logic [BCD_DIGIT_W-1:0] bHi,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] sumLo,
    output logic [BCD_DIGIT_W-1:0] sumHi,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] tLo;
    logic [BCD_DIGIT_W:0] tHi;
    logic                 midCarry;

    always_comb begin
        tLo      = 5'(aLo) + 5'(bLo) + 5'(cin);
        midCarry = tLo > 5'(BCD_MAX);
        sumLo    = midCarry ? 4'(tLo - 5'(BCD_RADIX)) : tLo[BCD_DIGIT_W-1:0];

        tHi      = 5'(aHi) + 5'(bHi) + 5'(midCarry);
        cout     = tHi > 5'(BCD_MAX);
        sumHi    = cout ? 4'(tHi - 5'(BCD_RADIX)) : tHi[BCD_DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_add_sequencer.sv
// rtl/bcd_add_sequencer.sv - serial wide BCD adder built on one digit-pair slice
//
// Purpose: adds two DIGITS-wide packed BCD operands by running a single
//          two-digit slice over the operands, least-significant pair first,
//          with the decimal carry held in a register between passes.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   start_valid  in   request to begin an addition
//   start_ready  out  high only in IDLE
//   a_bcd        in   operand A, digit 0 in bits [3:0]
//   b_bcd        in   operand B, same packing
//   carry_in     in   decimal carry into digit 0
//   sum_bcd      out  registered result (held between completions)
//   carry_out    out  decimal carry out of the top digit
//   done         out  one-cycle pulse when the result is valid
//   busy         out  high in ADD and DONE
//   error        out  an operand digit exceeded 9; held with the result
// DIGITS must be even and at least 2.
module bcd_add_sequencer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a_bcd,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b_bcd,
    input  logic                          carry_in,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum_bcd,
    output logic                          carry_out,
    output logic                          done,
    output logic                          busy,
    output logic                          error
);

    localparam int PAIRS  = DIGITS / 2;
    localparam int WIDTH  = BCD_DIGIT_W * DIGITS;
    localparam int PAIR_W = 2 * BCD_DIGIT_W;
    localparam int IDX_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAIRS - 1);

    bcdStateT          state;
    logic [IDX_W-1:0]  idx;
    logic [WIDTH-1:0]  aReg;
    logic [WIDTH-1:0]  bReg;
    logic [WIDTH-1:0]  workReg;
    logic              carryReg;

    logic              operandsValid;
    logic [PAIR_W-1:0] aPair;
    logic [PAIR_W-1:0] bPair;
    logic [WIDTH-1:0]  workNext;
    logic [BCD_DIGIT_W-1:0] sumLo;
    logic [BCD_DIGIT_W-1:0] sumHi;
    logic              sliceCarry;

    // Screened on the live inputs so a bad operand skips ADD entirely.
    always_comb begin
        operandsValid = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (!bcd_digit_valid(a_bcd[BCD_DIGIT_W*d +: BCD_DIGIT_W]) ||
                !bcd_digit_valid(b_bcd[BCD_DIGIT_W*d +: BCD_DIGIT_W])) begin
                operandsValid = 1'b0;
            end
        end
    end

    // Select the operand pair for this pass and splice the slice result
    // back into the working register at the same position.
    always_comb begin
        aPair    = '0;
        bPair    = '0;
        workNext = workReg;
        for (int k = 0; k < PAIRS; k++) begin
            if (int'(idx) == k) begin
                aPair = aReg[PAIR_W*k +: PAIR_W];
                bPair = bReg[PAIR_W*k +: PAIR_W];
                workNext[PAIR_W*k +: PAIR_W] = {sumHi, sumLo};
            end
        end
    end

    bcd_pair_adder u_slice (
        .aLo   (aPair[BCD_DIGIT_W-1:0]),
        .aHi   (aPair[PAIR_W-1:BCD_DIGIT_W]),
        .bLo   (bPair[BCD_DIGIT_W-1:0]),
        .bHi   (bPair[PAIR_W-1:BCD_DIGIT_W]),
        .cin   (carryReg),
        .sumLo (sumLo),
        .sumHi (sumHi),
        .cout  (sliceCarry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            aReg        <= '0;
            bReg        <= '0;
            workReg     <= '0;
            carryReg    <= 1'b0;
            sum_bcd     <= '0;
            carry_out   <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        aReg        <= a_bcd;
                        bReg        <= b_bcd;
                        carryReg    <= carry_in;
                        idx         <= '0;
                        workReg     <= '0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (operandsValid) begin
                            state <= ADD;
                        end else begin
                            state     <= DONE;
                            sum_bcd   <= '0;
                            carry_out <= 1'b0;
                            error     <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                end
                ADD: begin
                    workReg  <= workNext;
                    carryReg <= sliceCarry;
                    idx      <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        sum_bcd   <= workNext;
                        carry_out <= sliceCarry;
                        error     <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// tb/tb_bcd_add_sequencer.sv - directed self-checking bench for bcd_add_sequencer
module tb_bcd_add_sequencer;

    logic        clk;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] a_bcd;
    logic [31:0] b_bcd;
    logic        carry_in;
    logic [31:0] sum_bcd;
    logic        carry_out;
    logic        done;
    logic        busy;
    logic        error;

    int total = 0;
    int bad   = 0;

    bcd_add_sequencer #(.DIGITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_bcd       (a_bcd),
        .b_bcd       (b_bcd),
        .carry_in    (carry_in),
        .sum_bcd     (sum_bcd),
        .carry_out   (carry_out),
        .done        (done),
        .busy        (busy),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One request from IDLE; lat counts edges after the accepting edge until done.
    task automatic runAdd(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [31:0] expSum, input logic expCarry,
                          input logic expErr, input int expLat);
        int lat;
        a_bcd       = a;
        b_bcd       = b;
        carry_in    = cin;
        start_valid = 1'b1;
        check({tag, ".ready"}, 64'(start_ready), 64'd1);
        step();
        start_valid = 1'b0;
        a_bcd       = 32'h0;
        b_bcd       = 32'h0;
        carry_in    = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        check({tag, ".lat"},   64'(lat),       64'(expLat));
        check({tag, ".sum"},   64'(sum_bcd),   64'(expSum));
        check({tag, ".cout"},  64'(carry_out), 64'(expCarry));
        check({tag, ".err"},   64'(error),     64'(expErr));
        check({tag, ".busy"},  64'(busy),      64'd1);
        step();
        check({tag, ".pulse"}, 64'(done),        64'd0);
        check({tag, ".idle"},  64'(start_ready), 64'd1);
    endtask

    initial begin
        int          lat;
        int          sawDone;
        logic [31:0] doneMask;
        logic [31:0] readyMask;

        reset       = 1'b1;
        start_valid = 1'b0;
        a_bcd       = 32'h0;
        b_bcd       = 32'h0;
        carry_in    = 1'b0;
        step();
        step();
        check("rst.sum",   64'(sum_bcd),     64'd0);
        check("rst.cout",  64'(carry_out),   64'd0);
        check("rst.done",  64'(done),        64'd0);
        check("rst.busy",  64'(busy),        64'd0);
        check("rst.err",   64'(error),       64'd0);
        check("rst.ready", 64'(start_ready), 64'd1);
        reset = 1'b0;
        step();

        runAdd("add19_23",  32'h00000019, 32'h00000023, 1'b0, 32'h00000042, 1'b0, 1'b0, 4);
        runAdd("ripple",    32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 4);
        runAdd("allnines",  32'h99999999, 32'h99999999, 1'b1, 32'h99999999, 1'b1, 1'b0, 4);
        runAdd("baddigit",  32'h0000000A, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b1, 0);
        runAdd("clearerr",  32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 4);
        runAdd("badhigh",   32'h12345678, 32'hF0000000, 1'b1, 32'h00000000, 1'b0, 1'b1, 0);
        runAdd("cinonly",   32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 4);

        // New operands offered mid-ADD must not disturb the running sum.
        a_bcd       = 32'h11111111;
        b_bcd       = 32'h22222222;
        carry_in    = 1'b0;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        check("ign.ready", 64'(start_ready), 64'd0);
        check("ign.busy",  64'(busy),        64'd1);
        a_bcd       = 32'h99999999;
        b_bcd       = 32'h99999999;
        carry_in    = 1'b1;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        check("ign.lat",  64'(lat),       64'd4);
        check("ign.sum",  64'(sum_bcd),   64'h33333333);
        check("ign.cout", 64'(carry_out), 64'd0);
        step();
        step();
        check("ign.noreq", 64'(busy), 64'd0);

        // Reset lands during the second ADD cycle.
        a_bcd       = 32'h00000001;
        b_bcd       = 32'h00000001;
        carry_in    = 1'b0;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rmid.sum",   64'(sum_bcd),     64'd0);
        check("rmid.busy",  64'(busy),        64'd0);
        check("rmid.done",  64'(done),        64'd0);
        check("rmid.ready", 64'(start_ready), 64'd1);
        sawDone = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) sawDone++;
        end
        check("rmid.nodone", 64'(sawDone), 64'd0);

        // start_valid held high: one acceptance every PAIRS+2 = 6 cycles.
        a_bcd       = 32'h12345678;
        b_bcd       = 32'h87654321;
        carry_in    = 1'b0;
        start_valid = 1'b1;
        step();
        doneMask  = 32'h0;
        readyMask = 32'h0;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (done) begin
                doneMask[i] = 1'b1;
                check("hold.sum",  64'(sum_bcd),   64'h99999999);
                check("hold.cout", 64'(carry_out), 64'd0);
            end
            if (start_ready) readyMask[i] = 1'b1;
        end
        check("hold.donemask",  64'(doneMask),  64'h00010410);
        check("hold.readymask", 64'(readyMask), 64'h00020820);
        start_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("end.idle", 64'(start_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_add_sequencer.md
Name: bcd_add_sequencer

Overview:
- Multi-cycle controller that adds two DIGITS-wide packed BCD operands.
- Drives one shared two-digit BCD adder slice serially, least-significant pair first.
- Ripples the decimal carry between pairs in a register.
- Sits between a register-file or host interface and the display/result path. Gives wide decimal addition for the area of one digit-pair adder.

Parameters:
- DIGITS, 8, operand width in BCD digits; must be even and >= 2.
- PAIRS, DIGITS/2, derived; number of adder passes; not overridden by users.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start_valid  in  1  request to begin an addition
- start_ready  out  1  controller can accept a request; high only in IDLE
- a_bcd  in  4*DIGITS  operand A, digit 0 in bits [3:0]
- b_bcd  in  4*DIGITS  operand B, same packing
- carry_in  in  1  decimal carry into digit 0
- sum_bcd  out  4*DIGITS  registered result
- carry_out  out  1  decimal carry out of the top digit
- done  out  1  one-cycle pulse: result, carry_out and error are valid
- busy  out  1  high in ADD and DONE
- error  out  1  an operand digit was > 9; held with the result

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE; sum_bcd=0, carry_out=0, done=0, busy=0, error=0, start_ready=1.
- Reset wins over every other event, including mid-ADD. Partial work is discarded and no done pulse is produced.
- States:
  - IDLE -> ADD on edge E0 where start_valid && start_ready, if all operand digits are valid.
  - IDLE -> DONE on E0 if any digit of a_bcd or b_bcd is > 9.
  - ADD -> ADD while pair index < PAIRS-1.
  - ADD -> DONE on the edge processing pair PAIRS-1.
  - DONE -> IDLE unconditionally.
- Capture at E0: a_bcd, b_bcd and carry_in are copied into internal registers, index=0. Input changes after E0 have no effect.
- Each ADD cycle:
  - Pair k is digits 2k and 2k+1; the slice adds them with the carry register.
  - The 2 result digits are written into the working register at positions 2k and 2k+1.
  - The carry register takes the slice carry; index increments.
- Slice arithmetic, per digit:
  - t = a + b + cin (5-bit).
  - If t > 9: digit = t - 10, carry = 1; else digit = t, carry = 0.
  - The low digit's carry feeds the high digit.
- Output update: on entry to DONE, sum_bcd takes the working register and carry_out takes the carry register. Between completions, sum_bcd and carry_out hold the previous result.
- Error path: on entry to DONE, sum_bcd=0, carry_out=0, error=1. Otherwise error=0 on entry to DONE.
- Latency: done is high in the cycle after edge E_PAIRS (E4 for DIGITS=8), or in the cycle after E0 on the error path.
- start_ready is next high after the DONE cycle. The minimum request-to-request spacing is PAIRS+2 cycles.
- start_valid during ADD/DONE is ignored, with no queueing.
- A request held high continuously is accepted again on the first IDLE edge.
- Overflow past DIGITS is reported only via carry_out; the sum wraps modulo 10^DIGITS.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W=4, BCD_MAX=9, BCD_RADIX=10.
  - State enum {IDLE, ADD, DONE}.
  - Helper function bcd_digit_valid.
- Sub-module bcd_pair_adder: combinational.
  - Inputs: two 4-bit digits each for A and B, plus 1-bit carry in.
  - Outputs: 2 sum digits and 1-bit carry out.
  - Instantiated once, and verified standalone exhaustively (10^4 x 2 cases).

Test Plan:
- DIGITS=8, a=00000019, b=00000023, cin=0 -> sum_bcd=00000042, carry_out=0, error=0, done high the cycle after E4.
- a=99999999, b=00000001, cin=0 -> sum_bcd=00000000, carry_out=1; carry propagates through all 4 passes.
- a=99999999, b=99999999, cin=1 -> sum_bcd=99999999, carry_out=1.
- a=0000000A, b=00000001 -> done the cycle after E0, error=1, sum_bcd=00000000, carry_out=0. A following valid request clears error.
- Toggle start_valid with new operands during ADD -> ignored, result from the first operands only. Assert reset during the second ADD cycle -> outputs 0, state IDLE, no done pulse.
- start_valid held high with a=12345678, b=87654321 -> sum 99999999, carry_out 0. Requests are accepted every PAIRS+2=6 cycles and start_ready is low between them.
